culsans_sram_arbiter: RTL
=========================

Name: culsans_sram_arbiter

Overview:
- Shares the single-port main SRAM (tc_sram macro, simulation or Xilinx variant) between NumReq requesters: per-core memory ports, the test-bench loader/DTM path, and the exit/tohost monitor.
- Round-robin arbitration; one SRAM access per cycle.
- Read data is routed back to the originating requester after the fixed SRAM latency.
- Sits between the culsans_top memory crossbar leaves and the i_sram instance.

Parameters:
- NumReq, 4, number of requesters (2..16).
- AddrWidth, 27, SRAM word-address width (80 Mi words needs 27 bits).
- DataWidth, 64, SRAM data width; byte-enable width is DataWidth/8.
- Latency, 1, SRAM read latency in cycles (1..4).
- MaxLockCycles, 16, maximum consecutive grants to one locked requester (optional feature only).

Ports:
- clk_i  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- req_i  in  NumReq  per-requester request; held until granted.
- we_i  in  NumReq  per-requester write enable.
- addr_i  in  NumReq*AddrWidth  per-requester word address.
- wdata_i  in  NumReq*DataWidth  per-requester write data.
- be_i  in  NumReq*DataWidth/8  per-requester byte enables.
- lock_i  in  NumReq  keep grant across back-to-back requests (optional feature only).
- gnt_o  out  NumReq  one-hot grant, combinational from req_i and state.
- rvalid_o  out  NumReq  response valid; one-hot or zero.
- rdata_o  out  DataWidth  response data, shared bus, qualified by rvalid_o.
- sram_req_o  out  1  SRAM access strobe.
- sram_we_o  out  1  SRAM write enable.
- sram_addr_o  out  AddrWidth  SRAM address.
- sram_wdata_o  out  DataWidth  SRAM write data.
- sram_be_o  out  DataWidth/8  SRAM byte enables.
- sram_rdata_i  in  DataWidth  SRAM read data, valid Latency cycles after the strobe.

Behaviour:
- Reset values:
  - rr_ptr = 0; response pipeline cleared; lock state IDLE with count 0.
  - gnt_o = 0, rvalid_o = 0, sram_req_o = 0 while rst is low.
  - rdata_o and sram_* data and address outputs are don't-care.
- Arbitration: the winner is the first requester with req_i set, scanning from rr_ptr upward with wrap-around (NumReq-1 wraps to 0).
- gnt_o[w] = 1 in the same cycle as the request.
- On grant, rr_ptr <= (w+1) mod NumReq. With no request, rr_ptr holds.
- SRAM side: sram_req_o = |gnt_o. The other sram_* outputs are a combinational mux of the winner's signals.
- Handshake:
  - A requester must hold req_i and its payload stable until gnt_o.
  - A transfer completes in the cycle where req_i & gnt_o.
  - Back-to-back grants to the same requester are allowed only when no other requester is waiting.
- Response pipeline: a Latency-deep shift register of {valid, index} is written every cycle.
- rvalid_o[index] = 1 exactly Latency cycles after the grant, for reads and writes alike (writes are acknowledged).
- rdata_o = sram_rdata_i, unregistered.
- Throughput: one grant per cycle sustained, no bubbles.
- Starvation bound: a requester with req_i held is granted within NumReq-1 grants to others.
- Reset mid-operation clears in-flight responses; no rvalid is produced for them.
- Assertions (simulation only):
  - gnt_o is one-hot or zero.
  - rvalid_o is one-hot or zero.
  - No gnt_o without req_i.

Optional Feature:
- Macro CULSANS_SRAM_ARB_LOCK_EN.
- Defined: a two-state FSM, IDLE and LOCKED.
  - IDLE -> LOCKED when a grant goes to w with lock_i[w] = 1. The FSM stores owner = w and sets count = 1.
  - In LOCKED, only owner can be granted. Other requests wait; the owner may idle without losing the lock.
  - Each owner grant increments count.
  - LOCKED -> IDLE when lock_i[owner] drops, or when count reaches MaxLockCycles. In the MaxLockCycles case, the next arbitration skips owner if any other request is pending.
  - Used for AMO/LR-SC read-modify-write sequences.
- Undefined: lock_i is ignored (port kept, unconnected internally) and pure round-robin applies.

Decomposition:
- Package culsans_sram_arb_pkg holds:
  - sram_req_t struct {we, addr, wdata, be}.
  - rsp_tag_t struct {valid, idx}.
  - the arb_state_e enum {IDLE, LOCKED}.
  - an IdxWidth = $clog2(NumReq) helper function.
- One sub-module: culsans_rr_arbiter. It is a parameterised round-robin priority picker (req vector plus pointer in, one-hot grant out) and is reused by the lock logic.

Test Plan:
- Single requester: req_i = 4'b0001, read at addr 0x100 preloaded with 0xDEADBEEF_00000001 -> gnt_o = 0001 same cycle; rvalid_o[0] 1 cycle later with that data.
- All four requesting continuously for 8 cycles -> grant order 0,1,2,3,0,1,2,3; rvalid_o follows the same order delayed by Latency.
- Write then read: requester 2 writes 0x1234 with be = 0x03 to addr 0x20, then reads it -> write rvalid after 1 cycle; read returns 0x1234 in the low bytes, upper bytes unchanged.
- Latency = 3, alternating requesters 1 and 3 -> each rvalid arrives exactly 3 cycles after its grant, routed to the correct index, with no cross-routing.
- Reset asserted with 2 reads in flight -> no rvalid after reset; first grant after reset goes to requester 0.
- With CULSANS_SRAM_ARB_LOCK_EN, MaxLockCycles = 4: requester 1 locked while requesters 0 and 2 request -> four grants to 1, then a grant to 2, then 0.

Source files
------------

// File: rtl/culsans_sram_arb_pkg.sv
// Shared types for the main-SRAM arbiter: request payload, response tag, lock FSM state.
// Struct widths are the maxima supported by the arbiter (AddrWidth/DataWidth must not exceed them).
package culsans_sram_arb_pkg;

    localparam int unsigned SramAddrWidth = 27;
    localparam int unsigned SramDataWidth = 64;
    localparam int unsigned MaxIdxWidth   = 4;

    typedef struct packed {
        logic                         we;
        logic [SramAddrWidth-1:0]     addr;
        logic [SramDataWidth-1:0]     wdata;
        logic [SramDataWidth/8-1:0]   be;
    } sram_req_t;

    typedef struct packed {
        logic                   valid;
        logic [MaxIdxWidth-1:0] idx;
    } rsp_tag_t;

    typedef enum logic {
        IDLE,
        LOCKED
    } arb_state_e;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/culsans_rr_arbiter.sv
// Round-robin priority picker: first set request at or above ptr, wrapping, as a one-hot grant.
module culsans_rr_arbiter #(
    parameter int unsigned N    = 4,
    parameter int unsigned IdxW = 2
) (
    input  logic [N-1:0]    req,
    input  logic [IdxW-1:0] ptr,
    output logic [N-1:0]    gnt
);

    int               j;
    logic             found;
    logic [IdxW-1:0]  jj;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        j     = 0;
        jj    = '0;
        for (int i = 0; i < int'(N); i++) begin
            j = int'(ptr) + i;
            if (j >= int'(N)) j = j - int'(N);
            jj = IdxW'(j);
            if (!found && req[jj]) begin
                gnt[jj] = 1'b1;
                found   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/culsans_sram_arbiter.sv
// Shares the single-port main SRAM between NumReq requesters, routing responses back by index.
// Define CULSANS_SRAM_ARB_LOCK_EN to let a requester hold the SRAM for RMW sequences.
module culsans_sram_arbiter
    import culsans_sram_arb_pkg::*;
#(
    parameter int unsigned NumReq        = 4,
    parameter int unsigned AddrWidth     = SramAddrWidth,
    parameter int unsigned DataWidth     = SramDataWidth,
    parameter int unsigned Latency       = 1,
    parameter int unsigned MaxLockCycles = 16
) (
    input  logic                          clk_i,
    input  logic                          rst,
    input  logic [NumReq-1:0]             req_i,
    input  logic [NumReq-1:0]             we_i,
    input  logic [NumReq*AddrWidth-1:0]   addr_i,
    input  logic [NumReq*DataWidth-1:0]   wdata_i,
    input  logic [NumReq*DataWidth/8-1:0] be_i,
    input  logic [NumReq-1:0]             lock_i,
    output logic [NumReq-1:0]             gnt_o,
    output logic [NumReq-1:0]             rvalid_o,
    output logic [DataWidth-1:0]          rdata_o,
    output logic                          sram_req_o,
    output logic                          sram_we_o,
    output logic [AddrWidth-1:0]          sram_addr_o,
    output logic [DataWidth-1:0]          sram_wdata_o,
    output logic [DataWidth/8-1:0]        sram_be_o,
    input  logic [DataWidth-1:0]          sram_rdata_i
);

    localparam int unsigned IdxW = idx_width(NumReq);
    localparam int unsigned BeW  = DataWidth / 8;

    logic [IdxW-1:0]   rr_ptr;
    logic [NumReq-1:0] req_arb;
    logic [NumReq-1:0] arb_gnt;
    logic [IdxW-1:0]   widx;
    logic              any_gnt;
    sram_req_t         win;
    rsp_tag_t          rsp_p [Latency];

    culsans_rr_arbiter #(
        .N    (NumReq),
        .IdxW (IdxW)
    ) u_rr (
        .req (req_arb),
        .ptr (rr_ptr),
        .gnt (arb_gnt)
    );

    assign gnt_o   = rst ? arb_gnt : '0;
    assign any_gnt = |gnt_o;

    always_comb begin
        widx = '0;
        win  = '0;
        for (int i = 0; i < int'(NumReq); i++) begin
            if (gnt_o[i]) begin
                widx      = IdxW'(i);
                win.we    = we_i[i];
                win.addr  = SramAddrWidth'(addr_i[i*AddrWidth +: AddrWidth]);
                win.wdata = SramDataWidth'(wdata_i[i*DataWidth +: DataWidth]);
                win.be    = (SramDataWidth/8)'(be_i[i*BeW +: BeW]);
            end
        end
    end

    assign sram_req_o   = any_gnt;
    assign sram_we_o    = win.we;
    assign sram_addr_o  = win.addr[AddrWidth-1:0];
    assign sram_wdata_o = win.wdata[DataWidth-1:0];
    assign sram_be_o    = win.be[BeW-1:0];

    // Pointer moves just past the winner, so the winner has lowest priority next cycle.
    always_ff @(posedge clk_i or negedge rst) begin
        if (!rst) begin
            rr_ptr <= '0;
        end else if (any_gnt) begin
            rr_ptr <= (widx == IdxW'(NumReq - 1)) ? '0 : widx + 1'b1;
        end
    end

`ifdef CULSANS_SRAM_ARB_LOCK_EN
    localparam int unsigned CntW = idx_width(MaxLockCycles + 1);

    arb_state_e      state_q, state_d;
    logic [IdxW-1:0] owner_q, owner_d;
    logic [CntW-1:0] count_q, count_d;

    assign req_arb = (state_q == LOCKED) ? (req_i & (NumReq'(1) << owner_q)) : req_i;

    always_ff @(posedge clk_i or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            count_q <= count_d;
        end
    end

    // Releasing on the count limit relies on rr_ptr already pointing past the owner.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        count_d = count_q;
        unique case (state_q)
            IDLE: begin
                if (any_gnt && lock_i[widx] && (MaxLockCycles > 1)) begin
                    state_d = LOCKED;
                    owner_d = widx;
                    count_d = CntW'(1);
                end
            end
            LOCKED: begin
                if (!lock_i[owner_q]) begin
                    state_d = IDLE;
                    count_d = '0;
                end else if (any_gnt) begin
                    if (count_q == CntW'(MaxLockCycles - 1)) begin
                        state_d = IDLE;
                        count_d = '0;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end
`else
    localparam int unsigned unused_max_lock = MaxLockCycles;
    logic unused_lock;

    assign unused_lock = ^lock_i;
    assign req_arb     = req_i;
`endif

    // Response stage boundary: tag travels Latency cycles alongside the SRAM read.
    always_ff @(posedge clk_i or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(Latency); i++) rsp_p[i] <= '0;
        end else begin
            rsp_p[0] <= '{valid: any_gnt, idx: MaxIdxWidth'(widx)};
            for (int i = 1; i < int'(Latency); i++) rsp_p[i] <= rsp_p[i-1];
        end
    end

    assign rvalid_o = rsp_p[Latency-1].valid ? (NumReq'(1) << rsp_p[Latency-1].idx) : '0;
    assign rdata_o  = sram_rdata_i;

`ifndef SYNTHESIS
    always @(posedge clk_i) begin
        if (rst) begin
            assert ($onehot0(gnt_o));
            assert ($onehot0(rvalid_o));
            assert ((gnt_o & ~req_i) == '0);
        end
    end
`endif

endmodule
